mult_product_accumulator: RTL and testbench

//   Downstream stage of the 4x4 array multiplier: consumes its 8-bit products over a

---
 rtl/mult_product_accumulator_if.sv | 47 ++++
 rtl/mult_product_accumulator.sv | 98 +++++++++
 tb/tb_mult_product_accumulator.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_product_accumulator_if.sv
// ---------------------------------------------------------------------------
// mult_product_accumulator_if
//   Bundles the control, product-input and result-output handshakes of the
//   product accumulator into one interface.
//
//   Signals
//     start       run request, sampled by the accumulator only while idle
//     len         number of products in the run, captured with start
//     prod_valid  product available from the multiplier
//     prod_ready  accumulator accepts a product this cycle
//     prod_data   unsigned product
//     res_valid   result held and valid
//     res_ready   consumer takes the result
//     res_data    accumulated sum (modulo 2**ACC_W)
//     res_ovf     sticky carry-out seen during the run
//     busy        accumulator is in a run or holding a result
//
//   Modports
//     master  producer/consumer side (drives start, len, products, res_ready)
//     slave   accumulator side
// ---------------------------------------------------------------------------
interface mult_product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int LEN_W  = 5
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic              busy;

  modport master (
    output start, len, prod_valid, prod_data, res_ready,
    input  prod_ready, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  start, len, prod_valid, prod_data, res_ready,
    output prod_ready, res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// ---------------------------------------------------------------------------
// mult_product_accumulator
//   Sums a programmed number of unsigned products from the 4x4 array
//   multiplier (dot-product style MAC) and presents the sum with a sticky
//   overflow flag on a valid/ready result port.
//
//   Ports
//     clk   in  clock, all logic on the rising edge
//     rst   in  synchronous reset, active-high
//     bus   slave modport of mult_product_accumulator_if
//             (start/len, prod_valid/prod_ready/prod_data,
//              res_valid/res_ready/res_data/res_ovf, busy)
//
//   Operation
//     IDLE  -> start captures len and clears the sum; len==0 skips to HOLD.
//     ACCUM -> prod_ready high; each transfer adds one product and counts
//              down; the transfer that takes the count from 1 ends the run.
//     HOLD  -> res_valid high with the sum stable until res_ready.
//   All outputs are decoded from registered state, so there is no
//   combinational path from any input to any output.
// ---------------------------------------------------------------------------
module mult_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int LEN_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  mult_product_accumulator_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_xfer;
  logic [ACC_W:0]   w_sum;

  // prod_ready is a pure state decode, so a transfer is just valid in ACCUM.
  assign w_xfer = (r_state == S_ACCUM) && bus.prod_valid;

  // One bit wider than the accumulator so the carry-out lands in w_sum[ACC_W].
  assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'(bus.prod_data);

  assign bus.prod_ready = (r_state == S_ACCUM);
  assign bus.res_valid  = (r_state == S_HOLD);
  assign bus.res_data   = r_acc;
  assign bus.res_ovf    = r_ovf;
  assign bus.busy       = (r_state != S_IDLE);

  // NOTE: every register here updates with <= so all of them see the values
  // from before the edge; mixing in = would make the result depend on
  // statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The previous result stays visible until a new run clears it.
          if (bus.start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= bus.len;
            r_state <= (bus.len == '0) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            r_cnt <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mult_product_accumulator
//   Directed bench for mult_product_accumulator. Inputs change and outputs
//   are sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_mult_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 12;
  localparam int LEN_W  = 5;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  mult_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mult_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one cycle; returns at the falling edge after the
  // rising edge that sampled it.
  task automatic start_run(input logic [LEN_W-1:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  // Offer one product after 'gap' idle cycles; returns at the falling edge
  // after the rising edge that took it. ok=0 if prod_ready never came.
  task automatic push(input logic [PROD_W-1:0] d, input int gap, output bit ok);
    bus.prod_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.prod_ready) begin
        ok = 1'b1;
        xfers++;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy});
    end
    checks++;
    if (bus.res_data !== 12'd0) begin
      failures++;
      $display("FAIL reset_data: got %0d expected 0", bus.res_data);
    end
    rst = 1'b0;
    // A product offered while idle must not be consumed.
    bus.prod_valid = 1'b1;
    bus.prod_data  = 8'hFF;
    repeat (5) @(negedge clk);
    bus.prod_valid = 1'b0;
    checks++;
    if ({bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy} !== 4'b0000 ||
        bus.res_data !== 12'd0) begin
      failures++;
      $display("FAIL idle_stable: flags %b data %0d expected 0000 / 0",
               {bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy}, bus.res_data);
    end
  endtask

  task automatic release_result(input string name);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: res_valid %b busy %b expected 0 0",
               name, bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_basic_sum;
    bit ok;
    start_run(5'd3);
    checks++;
    if (bus.prod_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_accum_entry: prod_ready %b busy %b expected 1 1",
               bus.prod_ready, bus.busy);
    end
    push(8'd225, 0, ok);
    push(8'd225, 0, ok);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: res_valid %b expected 0", bus.res_valid);
    end
    push(8'd225, 0, ok);
    checks++;
    if (!ok || bus.res_valid !== 1'b1 || bus.prod_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: ok %b res_valid %b prod_ready %b expected 1 1 0",
               ok, bus.res_valid, bus.prod_ready);
    end
    checks++;
    if (bus.res_data !== 12'h2A3 || bus.res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: data %0d ovf %b expected 675 0", bus.res_data, bus.res_ovf);
    end
    release_result("basic");
    checks++;
    if (bus.res_data !== 12'h2A3) begin
      failures++;
      $display("FAIL basic_data_kept: data %0d expected 675", bus.res_data);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    start_run(5'd20);
    for (int i = 0; i < 20; i++) begin
      push(8'd225, 0, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || bus.res_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_complete: ok %b res_valid %b expected 1 1", all_ok, bus.res_valid);
    end
    checks++;
    if (bus.res_data !== 12'd404 || bus.res_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_result: data %0d ovf %b expected 404 1", bus.res_data, bus.res_ovf);
    end
    release_result("ovf");
  endtask

  task automatic test_gaps_and_ignored_start;
    bit ok;
    bit all_ok;
    bit stable;
    all_ok = 1'b1;
    xfers  = 0;
    start_run(5'd4);
    push(8'd1, 0, ok); all_ok &= ok;
    push(8'd2, 2, ok); all_ok &= ok;
    // start pulse during ACCUM with a different length must be ignored.
    bus.start = 1'b1;
    bus.len   = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
    push(8'd3, 3, ok); all_ok &= ok;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
      failures++;
      $display("FAIL gaps_still_accum: res_valid %b prod_ready %b expected 0 1",
               bus.res_valid, bus.prod_ready);
    end
    push(8'd4, 1, ok); all_ok &= ok;
    checks++;
    if (!all_ok || xfers != 4) begin
      failures++;
      $display("FAIL gaps_transfers: ok %b transfers %0d expected 1 4", all_ok, xfers);
    end
    // Hold the result for 5 cycles with a stray start in the middle.
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.len   = 5'd3;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 12'd10 || bus.res_ovf !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.len   = '0;
    checks++;
    if (!stable || bus.res_valid !== 1'b1 || bus.res_data !== 12'd10) begin
      failures++;
      $display("FAIL gaps_hold_stable: stable %b res_valid %b data %0d expected 1 1 10",
               stable, bus.res_valid, bus.res_data);
    end
    release_result("gaps");
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
      failures++;
      $display("FAIL gaps_no_restart: busy %b prod_ready %b expected 0 0",
               bus.busy, bus.prod_ready);
    end
  endtask

  task automatic test_zero_length;
    start_run(5'd0);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.prod_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_flags: res_valid %b prod_ready %b expected 1 0",
               bus.res_valid, bus.prod_ready);
    end
    checks++;
    if (bus.res_data !== 12'd0 || bus.res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_result: data %0d ovf %b expected 0 0", bus.res_data, bus.res_ovf);
    end
    release_result("zero_len");
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    start_run(5'd5);
    push(8'd225, 0, ok);
    push(8'd225, 0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy} !== 4'b0000 ||
        bus.res_data !== 12'd0) begin
      failures++;
      $display("FAIL midrun_reset: flags %b data %0d expected 0000 / 0",
               {bus.prod_ready, bus.res_valid, bus.res_ovf, bus.busy}, bus.res_data);
    end
    start_run(5'd1);
    push(8'd9, 0, ok);
    checks++;
    if (!ok || bus.res_valid !== 1'b1 || bus.res_data !== 12'd9 || bus.res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrun_new_run: ok %b res_valid %b data %0d ovf %b expected 1 1 9 0",
               ok, bus.res_valid, bus.res_data, bus.res_ovf);
    end
    release_result("midrun");
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.res_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_sum();
    test_overflow();
    test_gaps_and_ignored_start();
    test_zero_length();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
